// File: rtl/conv_patch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_ctrl_pkg
// Brief  : Shared types and constants for the convolution patch controller.
// Rev    : 1.0  initial release
// ============================================================================
package conv_ctrl_pkg;

    localparam int DIM_W_DEF  = 4;
    localparam int IMG_AW_DEF = 8;

    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam int          FP_SIGN_BIT = 31;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHECK   = 4'd1,
        S_FETCH   = 4'd2,
        S_DRAIN   = 4'd3,
        S_RUN     = 4'd4,
        S_WAIT    = 4'd5,
        S_WRITE   = 4'd6,
        S_ADVANCE = 4'd7,
        S_FIN     = 4'd8
    } state_e;

endpackage
`default_nettype wire

// File: rtl/conv_patch_controller_if.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_controller_if
// Brief  : Image-memory, patch-buffer, engine and output-memory bus bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface conv_patch_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int IMG_AW     = 8
);
    logic                  img_rd_en;
    logic [IMG_AW-1:0]     img_addr;
    logic [DATA_WIDTH-1:0] img_data;

    logic                  patch_wr_en;
    logic [ADDR_WIDTH-1:0] patch_wr_addr;
    logic [DATA_WIDTH-1:0] patch_wr_data;

    logic                  dp_start;
    logic [ADDR_WIDTH-1:0] dp_vec_length;
    logic                  dp_done;
    logic [DATA_WIDTH-1:0] dp_result;

    logic                  out_wr_en;
    logic [IMG_AW-1:0]     out_wr_addr;
    logic [DATA_WIDTH-1:0] out_wr_data;

    modport master (
        output img_rd_en, img_addr,
        input  img_data,
        output patch_wr_en, patch_wr_addr, patch_wr_data,
        output dp_start, dp_vec_length,
        input  dp_done, dp_result,
        output out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        input  img_rd_en, img_addr,
        output img_data,
        input  patch_wr_en, patch_wr_addr, patch_wr_data,
        input  dp_start, dp_vec_length,
        output dp_done, dp_result,
        input  out_wr_en, out_wr_addr, out_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/conv_patch_controller_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_addr_gen
// Brief  : ky/kx patch walker producing image and patch-buffer addresses.
// Rev    : 1.0  initial release
// ============================================================================
module conv_patch_addr_gen #(
    parameter int ADDR_WIDTH = 4,
    parameter int IMG_AW     = 8,
    parameter int DIM_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  step_i,
    input  logic [1:0]            k_i,
    input  logic [DIM_W-1:0]      img_w_i,
    input  logic [DIM_W-1:0]      oy_i,
    input  logic [DIM_W-1:0]      ox_i,
    output logic [IMG_AW-1:0]     img_addr_o,
    output logic [ADDR_WIDTH-1:0] patch_addr_o,
    output logic                  last_o
);

    logic [1:0] ky_q, ky_d;
    logic [1:0] kx_q, kx_d;

    assign last_o = (ky_q == k_i - 2'd1) && (kx_q == k_i - 2'd1);

    assign img_addr_o = (IMG_AW'(oy_i) + IMG_AW'(ky_q)) * IMG_AW'(img_w_i)
                      + IMG_AW'(ox_i) + IMG_AW'(kx_q);

    assign patch_addr_o = ADDR_WIDTH'(ky_q) * ADDR_WIDTH'(k_i) + ADDR_WIDTH'(kx_q);

    // The walk wraps to (0,0) after the last element so the next patch starts clean.
    always_comb begin
        ky_d = ky_q;
        kx_d = kx_q;
        if (clr_i || (step_i && last_o)) begin
            ky_d = 2'd0;
            kx_d = 2'd0;
        end else if (step_i) begin
            if (kx_q == k_i - 2'd1) begin
                kx_d = 2'd0;
                ky_d = ky_q + 2'd1;
            end else begin
                kx_d = kx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ky_q <= 2'd0;
            kx_q <= 2'd0;
        end else begin
            ky_q <= ky_d;
            kx_q <= kx_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_patch_controller.sv
`default_nettype none
// ============================================================================
// Module : conv_patch_controller
// Brief  : Gathers k x k patches, runs the dot-product engine, stores results.
//          Optional macro RELU_EN clamps negative results to +0.0.
// Rev    : 1.0  initial release
// ============================================================================
module conv_patch_controller
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int IMG_AW     = IMG_AW_DEF,
    parameter int DIM_W      = DIM_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [DIM_W-1:0]         img_h_i,
    input  logic [DIM_W-1:0]         img_w_i,
    input  logic [1:0]               k_size_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    conv_patch_controller_if.master  bus
);

    state_e                state_q, state_d;
    logic [DIM_W-1:0]      h_q, w_q, oy_q, ox_q, out_h_q, out_w_q;
    logic [1:0]            k_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  err_q;
    logic                  dp_done_prev_q;
    logic                  pwr_en_q;
    logic [ADDR_WIDTH-1:0] pwr_addr_q;

    logic                  gen_clr, gen_step, gen_last;
    logic [IMG_AW-1:0]     gen_img_addr;
    logic [ADDR_WIDTH-1:0] gen_patch_addr;
    logic                  rd_en, dp_start, wr_en;
    logic                  cfg_bad, last_pos, dp_rise;
    logic [DATA_WIDTH-1:0] wr_data;

    assign cfg_bad  = (k_q == 2'd0) || (DIM_W'(k_q) > h_q) || (DIM_W'(k_q) > w_q);
    assign last_pos = (ox_q == out_w_q - DIM_W'(1)) && (oy_q == out_h_q - DIM_W'(1));
    // A level left high by the previous job must not count as completion.
    assign dp_rise  = bus.dp_done && !dp_done_prev_q;

    conv_patch_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMG_AW     (IMG_AW),
        .DIM_W      (DIM_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (gen_clr),
        .step_i       (gen_step),
        .k_i          (k_q),
        .img_w_i      (w_q),
        .oy_i         (oy_q),
        .ox_i         (ox_q),
        .img_addr_o   (gen_img_addr),
        .patch_addr_o (gen_patch_addr),
        .last_o       (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gen_clr  = 1'b0;
        gen_step = 1'b0;
        rd_en    = 1'b0;
        dp_start = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_CHECK;
            S_CHECK: begin
                gen_clr = 1'b1;
                state_d = cfg_bad ? S_FIN : S_FETCH;
            end
            S_FETCH: begin
                rd_en    = 1'b1;
                gen_step = 1'b1;
                if (gen_last) state_d = S_DRAIN;
            end
            S_DRAIN:   state_d = S_RUN;
            S_RUN: begin
                dp_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT:    if (dp_rise) state_d = S_WRITE;
            S_WRITE: begin
                wr_en   = 1'b1;
                state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                gen_clr = 1'b1;
                state_d = last_pos ? S_FIN : S_FETCH;
            end
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q            <= '0;
            w_q            <= '0;
            k_q            <= 2'd0;
            oy_q           <= '0;
            ox_q           <= '0;
            out_h_q        <= '0;
            out_w_q        <= '0;
            result_q       <= '0;
            err_q          <= 1'b0;
            dp_done_prev_q <= 1'b0;
            pwr_en_q       <= 1'b0;
            pwr_addr_q     <= '0;
        end else begin
            dp_done_prev_q <= bus.dp_done;
            // Read data lands one cycle after the strobe, so the write trails it.
            pwr_en_q       <= rd_en;
            pwr_addr_q     <= gen_patch_addr;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        h_q   <= img_h_i;
                        w_q   <= img_w_i;
                        k_q   <= k_size_i;
                        err_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    oy_q    <= '0;
                    ox_q    <= '0;
                    out_h_q <= h_q - DIM_W'(k_q) + DIM_W'(1);
                    out_w_q <= w_q - DIM_W'(k_q) + DIM_W'(1);
                    if (cfg_bad) err_q <= 1'b1;
                end
                S_WAIT: begin
                    if (dp_rise) result_q <= bus.dp_result;
                end
                S_ADVANCE: begin
                    if (ox_q == out_w_q - DIM_W'(1)) begin
                        ox_q <= '0;
                        oy_q <= oy_q + DIM_W'(1);
                    end else begin
                        ox_q <= ox_q + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RELU_EN
    assign wr_data = result_q[FP_SIGN_BIT] ? DATA_WIDTH'(FP_ZERO) : result_q;
`else
    assign wr_data = result_q;
`endif

    assign busy_o = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done_o = (state_q == S_FIN);
    assign err_o  = err_q;

    assign bus.img_rd_en     = rd_en;
    assign bus.img_addr      = rd_en ? gen_img_addr : '0;
    assign bus.patch_wr_en   = pwr_en_q;
    assign bus.patch_wr_addr = pwr_addr_q;
    assign bus.patch_wr_data = pwr_en_q ? bus.img_data : '0;
    assign bus.dp_start      = dp_start;
    assign bus.dp_vec_length = busy_o ? ADDR_WIDTH'(k_q) * ADDR_WIDTH'(k_q) : '0;
    assign bus.out_wr_en     = wr_en;
    assign bus.out_wr_addr   = wr_en ? IMG_AW'(oy_q) * IMG_AW'(out_w_q) + IMG_AW'(ox_q) : '0;
    assign bus.out_wr_data   = wr_en ? wr_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv_patch_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_patch_controller
// Brief  : Directed bench with image memory, engine and output-write model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_patch_controller;

    localparam int DW      = 32;
    localparam int AW      = 4;
    localparam int IAW     = 8;
    localparam int DIMW    = 4;
    localparam int ENG_LAT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DIMW-1:0] img_h = '0;
    logic [DIMW-1:0] img_w = '0;
    logic [1:0]      k_size = 2'd0;
    logic            busy, done, err;

    conv_patch_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_AW(IAW)) bus ();

    conv_patch_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_AW     (IAW),
        .DIM_W      (DIMW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .img_h_i  (img_h),
        .img_w_i  (img_w),
        .k_size_i (k_size),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Integer-valued FP32 helpers
    function automatic int fp2int(input logic [31:0] f);
        int e, mag;
        if (f[30:0] == 31'd0) return 0;
        e   = int'(f[30:23]);
        mag = int'({1'b1, f[22:0]}) >>> (150 - e);
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int          mag, p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) p = i;
        m = 32'(mag) << (23 - p);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
    endfunction

    logic [31:0] img_mem [256];
    logic [31:0] pbuf    [16];
    logic [31:0] filt    [9];

    function automatic logic [31:0] engine_dot(input int n);
        int s = 0;
        for (int i = 0; i < n && i < 9; i++) s += fp2int(pbuf[i]) * fp2int(filt[i]);
        return int2fp(s);
    endfunction

    always @(posedge clk) begin
        if (bus.img_rd_en) bus.img_data <= img_mem[bus.img_addr];
        if (bus.patch_wr_en) pbuf[bus.patch_wr_addr] <= bus.patch_wr_data;
    end

    // Engine: done stays high as a level until one cycle after the next start.
    int          eng_cnt;
    logic [31:0] eng_res;
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.dp_done   <= 1'b0;
            bus.dp_result <= '0;
            eng_cnt       <= 0;
        end else if (bus.dp_start) begin
            eng_cnt <= ENG_LAT;
            eng_res <= engine_dot(int'(bus.dp_vec_length));
        end else if (eng_cnt > 1) begin
            bus.dp_done <= 1'b0;
            eng_cnt     <= eng_cnt - 1;
        end else if (eng_cnt == 1) begin
            bus.dp_done   <= 1'b1;
            bus.dp_result <= eng_res;
            eng_cnt       <= 0;
        end
    end

    // Expected-behaviour model
    logic [31:0] exp_rd[$], exp_pa[$], exp_pd[$], exp_wa[$], exp_wd[$];
    logic [31:0] rd_log[$], pa_log[$], wr_log[$];
    int          exp_dp, dp_cnt, wr_cnt, exp_vlen;
    bit          chk_en = 1'b0;

    task automatic model(input int h, input int w, input int k, input int fsign);
        int sum, a;
        logic [31:0] v;
        exp_rd.delete(); exp_pa.delete(); exp_pd.delete(); exp_wa.delete(); exp_wd.delete();
        rd_log.delete(); pa_log.delete(); wr_log.delete();
        dp_cnt = 0; wr_cnt = 0; exp_dp = 0;
        exp_vlen = k * k;
        for (int i = 0; i < 9; i++) filt[i] = int2fp(fsign);
        if (k >= 1 && k <= h && k <= w) begin
            for (int oy = 0; oy <= h - k; oy++) begin
                for (int ox = 0; ox <= w - k; ox++) begin
                    sum = 0;
                    for (int ky = 0; ky < k; ky++) begin
                        for (int kx = 0; kx < k; kx++) begin
                            a = (oy + ky) * w + ox + kx;
                            exp_rd.push_back(32'(a));
                            exp_pa.push_back(32'(ky * k + kx));
                            exp_pd.push_back(img_mem[a]);
                            sum += fp2int(img_mem[a]) * fsign;
                        end
                    end
                    v = int2fp(sum);
`ifdef RELU_EN
                    if (v[31]) v = 32'h0;
`endif
                    exp_dp++;
                    exp_wa.push_back(32'(oy * (w - k + 1) + ox));
                    exp_wd.push_back(v);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (busy) chk("dp_vec_length", 32'(bus.dp_vec_length), 32'(exp_vlen));
            if (bus.img_rd_en) begin
                rd_log.push_back(32'(bus.img_addr));
                chk("read_expected", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) chk("img_addr", 32'(bus.img_addr), exp_rd.pop_front());
            end
            if (bus.patch_wr_en) begin
                pa_log.push_back(32'(bus.patch_wr_addr));
                chk("patch_expected", 32'(exp_pa.size() > 0), 32'd1);
                if (exp_pa.size() > 0) begin
                    chk("patch_wr_addr", 32'(bus.patch_wr_addr), exp_pa.pop_front());
                    chk("patch_wr_data", bus.patch_wr_data, exp_pd.pop_front());
                end
            end
            if (bus.dp_start) begin
                dp_cnt++;
                chk("dp_start_expected", 32'(dp_cnt <= exp_dp), 32'd1);
            end
            if (bus.out_wr_en) begin
                wr_cnt++;
                wr_log.push_back(bus.out_wr_data);
                chk("write_expected", 32'(exp_wa.size() > 0), 32'd1);
                if (exp_wa.size() > 0) begin
                    chk("out_wr_addr", 32'(bus.out_wr_addr), exp_wa.pop_front());
                    chk("out_wr_data", bus.out_wr_data, exp_wd.pop_front());
                end
            end
        end
    end

    task automatic do_start(input int h, input int w, input int k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        img_h  = DIMW'(h);
        img_w  = DIMW'(w);
        k_size = 2'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, input logic exp_err, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < max);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
        chk({tag, "_patch_left"}, 32'(exp_pa.size()), 32'd0);
        chk({tag, "_writes_left"}, 32'(exp_wa.size()), 32'd0);
        chk({tag, "_dp_starts"}, 32'(dp_cnt), 32'(exp_dp));
    endtask

    function automatic logic [31:0] log_at(input int idx, input int which);
        if (which == 0) return (idx < wr_log.size()) ? wr_log[idx] : 32'hDEAD_BEEF;
        if (which == 1) return (idx < rd_log.size()) ? rd_log[idx] : 32'hDEAD_BEEF;
        return (idx < pa_log.size()) ? pa_log[idx] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] lit_a  [4];
    logic [31:0] lit_rd [9];
    logic [31:0] lit_b  [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, dcnt;
        lit_a  = '{32'h42580000, 32'h427C0000, 32'h42B40000, 32'h42C60000};
        lit_rd = '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd13, 32'd14, 32'd15};
        lit_b  = '{32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        for (int i = 0; i < 256; i++) img_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_en", 32'(bus.img_rd_en), 32'd0);
        chk("rst_dp_start", 32'(bus.dp_start), 32'd0);
        chk("rst_out_wr_en", 32'(bus.out_wr_en), 32'd0);
        chk("rst_patch_wr_en", 32'(bus.patch_wr_en), 32'd0);
        chk("rst_vec_length", 32'(bus.dp_vec_length), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // A: 4x4 image 1..16, k=3, all-ones filter, stray start while busy
        for (int i = 0; i < 16; i++) img_mem[i] = int2fp(i + 1);
        model(4, 4, 3, 1);
        chk_en = 1'b1;
        do_start(4, 4, 3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; img_h = 4'd2; img_w = 4'd2; k_size = 2'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("A", 400, 1'b0, n);
        end_checks("A");
        chk("A_write_count", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("A_lit_data", log_at(i, 0), lit_a[i]);
        for (int i = 0; i < 9; i++) chk("A_pos11_img_addr", log_at(27 + i, 1), lit_rd[i]);
        for (int i = 0; i < 9; i++) chk("A_pos11_patch_addr", log_at(27 + i, 2), 32'(i));

        // B: 2x2 image, k=1 copy
        for (int i = 0; i < 4; i++) img_mem[i] = lit_b[i];
        model(2, 2, 1, 1);
        do_start(2, 2, 1);
        wait_done("B", 200, 1'b0, n);
        end_checks("B");
        for (int i = 0; i < 4; i++) chk("B_copy_data", log_at(i, 0), lit_b[i]);

        // E1: k larger than image; E2: k=0
        model(2, 2, 3, 1);
        do_start(2, 2, 3);
        wait_done("E1", 20, 1'b1, n);
        chk("E1_latency_ok", 32'(n <= 3), 32'd1);
        end_checks("E1");
        chk("E1_no_reads", 32'(rd_log.size()), 32'd0);
        chk("E1_no_writes", 32'(wr_cnt), 32'd0);
        model(4, 4, 0, 1);
        do_start(4, 4, 0);
        wait_done("E2", 20, 1'b1, n);
        chk("E2_latency_ok", 32'(n <= 3), 32'd1);
        end_checks("E2");
        chk("E2_no_reads", 32'(rd_log.size()), 32'd0);
        chk("E2_no_writes", 32'(wr_cnt), 32'd0);

        // C: negative filter
        for (int i = 0; i < 16; i++) img_mem[i] = int2fp(i + 1);
        model(4, 4, 3, -1);
        do_start(4, 4, 3);
        wait_done("C", 400, 1'b0, n);
        end_checks("C");
`ifdef RELU_EN
        chk("C_first_write", log_at(0, 0), 32'h00000000);
`else
        chk("C_first_write", log_at(0, 0), 32'hC2580000);
`endif

        // R: reset while waiting on the engine for the second output
        model(4, 4, 3, 1);
        do_start(4, 4, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dp_cnt < 2 && n < 200);
        chk("R_reached_second_run", 32'(dp_cnt), 32'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("R_busy", 32'(busy), 32'd0);
        chk("R_done", 32'(done), 32'd0);
        chk("R_err", 32'(err), 32'd0);
        chk("R_rd_en", 32'(bus.img_rd_en), 32'd0);
        chk("R_dp_start", 32'(bus.dp_start), 32'd0);
        chk("R_out_wr_en", 32'(bus.out_wr_en), 32'd0);
        chk("R_vec_length", 32'(bus.dp_vec_length), 32'd0);
        exp_rd.delete(); exp_pa.delete(); exp_pd.delete(); exp_wa.delete(); exp_wd.delete();
        exp_dp = dp_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("R_no_done", 32'(dcnt), 32'd0);
        chk("R_write_count", 32'(wr_cnt), 32'd1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
